mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single 128-bit memory port between the UART programmer (write-only, fire-and-forget, ignores grant) and the CPU instruction and data requesters. Buffers programmer writes in a small FIFO, gives them absolute priority, and round-robins the two CPU ports. While programming is active, CPU requesters are locked out. Read responses are routed back in order via an outstanding-ID queue.

Parameters:
PROG_FIFO_DEPTH, 2, programmer write buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 4, max in-flight reads (power of 2, >=1)
ADDR_W, 32, address width
DATA_W, 128, data width (strobe width DATA_W/8)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
prog_req_i  in  1  programmer write valid (one-cycle pulse per word, no backpressure)
prog_addr_i  in  ADDR_W  programmer address
prog_wdata_i  in  DATA_W  programmer write data
prog_wstrb_i  in  DATA_W/8  programmer byte strobes
prog_lock_i  in  1  programming in progress; blocks CPU grants
ic_req_i  in  1  icache read request
ic_addr_i  in  ADDR_W  icache address
ic_gnt_o  out  1  icache request accepted
ic_rvalid_o  out  1  icache read data valid
dc_req_i  in  1  dcache request
dc_we_i  in  1  dcache write enable
dc_addr_i  in  ADDR_W  dcache address
dc_wdata_i  in  DATA_W  dcache write data
dc_wstrb_i  in  DATA_W/8  dcache byte strobes
dc_gnt_o  out  1  dcache request accepted
dc_rvalid_o  out  1  dcache read data valid
rdata_o  out  DATA_W  read data, broadcast (= mem_rdata_i)
mem_req_o  out  1  downstream request
mem_gnt_i  in  1  downstream accept
mem_we_o  out  1  downstream write enable
mem_addr_o  out  ADDR_W  downstream address
mem_wdata_o  out  DATA_W  downstream write data
mem_wstrb_o  out  DATA_W/8  downstream strobes
mem_rvalid_i  in  1  downstream read data valid (one per granted read, in order, >=1 cycle after gnt)
mem_rdata_i  in  DATA_W  downstream read data
prog_overflow_o  out  1  sticky: programmer write dropped (FIFO full)
resp_err_o  out  1  sticky: mem_rvalid_i with no outstanding read

Behaviour:
- Reset: all outputs 0; FIFOs empty; RR pointer = icache; owner cleared; sticky flags cleared. Reset mid-transaction discards buffered writes and outstanding IDs.
- Programmer path: prog_req_i pushes {addr,wdata,wstrb} into prog FIFO; earliest downstream request cycle N+1. Push when full: word dropped, prog_overflow_o set until reset. Push and pop same cycle when full: pop frees slot, push accepted.
- Arbitration (when no held owner): priority 1 = prog FIFO non-empty; else if prog_lock_i=0, RR between ic/dc among active requests. RR pointer toggles to the other CPU port after each CPU handshake only.
- Read eligibility: ic request, or dc with dc_we_i=0, eligible only if ID queue not full (count < MAX_OUTSTANDING) or a pop occurs same cycle. dc writes ignore ID queue.
- CPU path combinational: mem_req_o/mem_* driven same cycle as selected *_req_i; *_gnt_o = mem_gnt_i && selected.
- Hold rule: if mem_req_o=1 and mem_gnt_i=0, owner is registered and kept next cycle regardless of new priorities/lock; CPU requester must hold req/fields stable until gnt. Programmer FIFO head popped only on mem_gnt_i.
- prog_lock_i rising while CPU owner held: hold completes first; no new CPU grant afterwards until lock low.
- ID queue: push requester ID (ic/dc) on every read handshake; on mem_rvalid_i pop head, assert ic_rvalid_o or dc_rvalid_o same cycle (combinational). Simultaneous push/pop allowed. mem_rvalid_i with empty queue: no rvalid, resp_err_o set sticky.
- Writes produce no response.

Decomposition:
- mem_arb_pkg: typedef enum logic [1:0] {ReqNone, ReqProg, ReqIcache, ReqDcache} req_id_t; struct mem_cmd_t {we, addr, wdata, wstrb}.
- Sub-module sync_fifo (parameterised WIDTH/DEPTH, push/pop/full/empty/count), instantiated twice: prog write buffer and ID queue.

Test Plan:
- Programmer pulses 3 words (addr 0x0,0x10,0x20), mem_gnt_i=1 -> mem_req_o cycles N+1..N+3, addrs in order, we=1, wstrb=0xFFFF.
- ic and dc both requesting reads continuously, no lock, gnt=1 -> grants alternate ic,dc,ic,dc; ID queue order matches; rvalid routed correctly with rdata 0xAAA.../0x555....
- prog_lock_i=1 with ic_req_i=1 -> ic_gnt_o stays 0 for 100 cycles; lock low -> ic granted next cycle.
- mem_gnt_i=0 for 5 cycles with dc owner, programmer word arrives -> dc fields held, dc granted first, programmer word issued next cycle.
- 4 reads outstanding (MAX_OUTSTANDING=4), 5th ic read -> no grant until mem_rvalid_i; same-cycle pop permits grant.
- 3 programmer pulses while gnt=0 (depth 2) -> prog_overflow_o=1, only first 2 words issued; mem_rvalid_i with empty queue -> resp_err_o=1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: requester IDs and the downstream command word.
package mem_arb_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 128;
    localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ReqNone,
        ReqProg,
        ReqIcache,
        ReqDcache
    } req_id_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_STRB_W-1:0] wstrb;
    } mem_cmd_t;

    function automatic logic is_cpu(input req_id_t id);
        return (id == ReqIcache) || (id == ReqDcache);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sync_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between buffered programmer writes (top priority) and round-robin
// icache/dcache requests; read responses are steered back via an in-order requester-ID queue.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned PROG_FIFO_DEPTH = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = MEM_ADDR_W,
    parameter int unsigned DATA_W          = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_req_i,
    input  logic [ADDR_W-1:0]   prog_addr_i,
    input  logic [DATA_W-1:0]   prog_wdata_i,
    input  logic [DATA_W/8-1:0] prog_wstrb_i,
    input  logic                prog_lock_i,
    input  logic                ic_req_i,
    input  logic [ADDR_W-1:0]   ic_addr_i,
    output logic                ic_gnt_o,
    output logic                ic_rvalid_o,
    input  logic                dc_req_i,
    input  logic                dc_we_i,
    input  logic [ADDR_W-1:0]   dc_addr_i,
    input  logic [DATA_W-1:0]   dc_wdata_i,
    input  logic [DATA_W/8-1:0] dc_wstrb_i,
    output logic                dc_gnt_o,
    output logic                dc_rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                prog_overflow_o,
    output logic                resp_err_o
);

    localparam int unsigned ID_CNT_W = $clog2(MAX_OUTSTANDING + 1);

    req_id_t  r_owner;
    req_id_t  w_owner_nxt;
    req_id_t  w_sel;
    req_id_t  w_id_head;
    logic     r_rr_dc;
    logic     w_rr_dc_nxt;
    logic     r_prog_ovf;
    logic     r_resp_err;
    mem_cmd_t w_prog_in;
    mem_cmd_t w_prog_head;
    mem_cmd_t w_cmd;
    logic     w_prog_full;
    logic     w_prog_empty;
    logic     w_prog_pop;
    logic [$clog2(PROG_FIFO_DEPTH+1)-1:0] w_prog_count_unused;
    logic [1:0]          w_id_head_raw;
    logic [ID_CNT_W-1:0] w_id_count;
    logic     w_id_full_unused;
    logic     w_id_empty;
    logic     w_id_push;
    logic     w_id_pop;
    logic     w_id_ok;
    logic     w_ic_elig;
    logic     w_dc_elig;
    logic     w_hs;

    assign w_prog_in = '{we: 1'b1, addr: prog_addr_i, wdata: prog_wdata_i, wstrb: prog_wstrb_i};

    sync_fifo #(
        .WIDTH ($bits(mem_cmd_t)),
        .DEPTH (PROG_FIFO_DEPTH)
    ) u_prog_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (prog_req_i),
        .i_pop   (w_prog_pop),
        .i_wdata (w_prog_in),
        .o_rdata (w_prog_head),
        .o_full  (w_prog_full),
        .o_empty (w_prog_empty),
        .o_count (w_prog_count_unused)
    );

    sync_fifo #(
        .WIDTH (2),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_id_push),
        .i_pop   (w_id_pop),
        .i_wdata (w_sel),
        .o_rdata (w_id_head_raw),
        .o_full  (w_id_full_unused),
        .o_empty (w_id_empty),
        .o_count (w_id_count)
    );

    assign w_id_head = req_id_t'(w_id_head_raw);
    assign w_id_pop  = rst_n && mem_rvalid_i && !w_id_empty;
    // A response popping this cycle frees an ID slot for a new read in the same cycle.
    assign w_id_ok   = (w_id_count < ID_CNT_W'(MAX_OUTSTANDING)) || w_id_pop;
    assign w_ic_elig = ic_req_i && w_id_ok;
    assign w_dc_elig = dc_req_i && (dc_we_i || w_id_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner    <= ReqNone;
            r_rr_dc    <= 1'b0;
            r_prog_ovf <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_rr_dc <= w_rr_dc_nxt;
            if (prog_req_i && w_prog_full && !w_prog_pop) r_prog_ovf <= 1'b1;
            if (mem_rvalid_i && w_id_empty)               r_resp_err <= 1'b1;
        end
    end

    // A stalled request keeps its owner regardless of new priorities or lock.
    always_comb begin
        w_owner_nxt = ReqNone;
        w_rr_dc_nxt = r_rr_dc;
        if (mem_req_o && !mem_gnt_i) w_owner_nxt = w_sel;
        if (w_hs && is_cpu(w_sel))   w_rr_dc_nxt = (w_sel == ReqIcache);
    end

    always_comb begin
        w_sel = ReqNone;
        if (!rst_n) begin
            w_sel = ReqNone;
        end else if (r_owner != ReqNone) begin
            w_sel = r_owner;
        end else if (!w_prog_empty) begin
            w_sel = ReqProg;
        end else if (!prog_lock_i) begin
            if (w_ic_elig && w_dc_elig) w_sel = r_rr_dc ? ReqDcache : ReqIcache;
            else if (w_ic_elig)         w_sel = ReqIcache;
            else if (w_dc_elig)         w_sel = ReqDcache;
        end
    end

    always_comb begin
        w_cmd = '0;
        case (w_sel)
            ReqProg:   w_cmd = w_prog_head;
            ReqIcache: w_cmd.addr = ic_addr_i;
            ReqDcache: w_cmd = '{we: dc_we_i, addr: dc_addr_i, wdata: dc_wdata_i, wstrb: dc_wstrb_i};
            default:   w_cmd = '0;
        endcase
    end

    assign mem_req_o   = (w_sel != ReqNone);
    assign w_hs        = mem_req_o && mem_gnt_i;
    assign w_prog_pop  = w_hs && (w_sel == ReqProg);
    assign w_id_push   = w_hs && ((w_sel == ReqIcache) || ((w_sel == ReqDcache) && !dc_we_i));
    assign mem_we_o    = w_cmd.we;
    assign mem_addr_o  = w_cmd.addr;
    assign mem_wdata_o = w_cmd.wdata;
    assign mem_wstrb_o = w_cmd.wstrb;
    assign ic_gnt_o    = w_hs && (w_sel == ReqIcache);
    assign dc_gnt_o    = w_hs && (w_sel == ReqDcache);
    assign ic_rvalid_o = w_id_pop && (w_id_head == ReqIcache);
    assign dc_rvalid_o = w_id_pop && (w_id_head == ReqDcache);
    assign rdata_o     = mem_rdata_i;
    assign prog_overflow_o = r_prog_ovf;
    assign resp_err_o      = r_resp_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus queues expected handshakes/responses,
// an independent monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

    localparam logic [1:0] S_PROG = 2'd1;
    localparam logic [1:0] S_IC   = 2'd2;
    localparam logic [1:0] S_DC   = 2'd3;
    localparam logic [127:0] D_IC = {32{4'hA}};
    localparam logic [127:0] D_DC = {32{4'h5}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         prog_req_i, prog_lock_i;
    logic [31:0]  prog_addr_i;
    logic [127:0] prog_wdata_i;
    logic [15:0]  prog_wstrb_i;
    logic         ic_req_i, ic_gnt_o, ic_rvalid_o;
    logic [31:0]  ic_addr_i;
    logic         dc_req_i, dc_we_i, dc_gnt_o, dc_rvalid_o;
    logic [31:0]  dc_addr_i;
    logic [127:0] dc_wdata_i;
    logic [15:0]  dc_wstrb_i;
    logic [127:0] rdata_o;
    logic         mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o, mem_rdata_i;
    logic [15:0]  mem_wstrb_o;
    logic         prog_overflow_o, resp_err_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .PROG_FIFO_DEPTH (2),
        .MAX_OUTSTANDING (4),
        .ADDR_W          (32),
        .DATA_W          (128)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .prog_req_i      (prog_req_i),
        .prog_addr_i     (prog_addr_i),
        .prog_wdata_i    (prog_wdata_i),
        .prog_wstrb_i    (prog_wstrb_i),
        .prog_lock_i     (prog_lock_i),
        .ic_req_i        (ic_req_i),
        .ic_addr_i       (ic_addr_i),
        .ic_gnt_o        (ic_gnt_o),
        .ic_rvalid_o     (ic_rvalid_o),
        .dc_req_i        (dc_req_i),
        .dc_we_i         (dc_we_i),
        .dc_addr_i       (dc_addr_i),
        .dc_wdata_i      (dc_wdata_i),
        .dc_wstrb_i      (dc_wstrb_i),
        .dc_gnt_o        (dc_gnt_o),
        .dc_rvalid_o     (dc_rvalid_o),
        .rdata_o         (rdata_o),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_wstrb_o     (mem_wstrb_o),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .prog_overflow_o (prog_overflow_o),
        .resp_err_o      (resp_err_o)
    );

    typedef struct {
        logic [1:0]   src;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  wstrb;
    } exp_mem_t;

    typedef struct {
        logic [1:0]   src;
        logic [127:0] data;
    } exp_rsp_t;

    exp_mem_t    exp_mem[$];
    exp_rsp_t    exp_rsp[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [127:0] prog_data(input logic [31:0] a);
        return {4{a ^ 32'h5EED_0000}};
    endfunction

    task automatic exp_rd(input logic [1:0] src, input logic [31:0] a, input logic [127:0] d);
        exp_mem.push_back('{src: src, we: 1'b0, addr: a, wdata: '0, wstrb: '0});
        exp_rsp.push_back('{src: src, data: d});
    endtask

    task automatic prog_word(input logic [31:0] a, input bit expect_issue);
        prog_req_i   = 1'b1;
        prog_addr_i  = a;
        prog_wdata_i = prog_data(a);
        prog_wstrb_i = 16'hFFFF;
        if (expect_issue)
            exp_mem.push_back('{src: S_PROG, we: 1'b1, addr: a, wdata: prog_data(a), wstrb: 16'hFFFF});
    endtask

    // Monitor: every downstream handshake and every read response is checked against the queues.
    initial begin
        exp_mem_t e;
        exp_rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mem_req_o && mem_gnt_i) begin
                if (exp_mem.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_hs_unexpected: got addr %0h want no handshake", mem_addr_o);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mem_addr", mem_addr_o, e.addr);
                    chk("mem_we", mem_we_o, e.we);
                    if (e.we) begin
                        chk("mem_wdata", mem_wdata_o, e.wdata);
                        chk("mem_wstrb", mem_wstrb_o, e.wstrb);
                    end
                    chk("ic_gnt", ic_gnt_o, e.src == S_IC);
                    chk("dc_gnt", dc_gnt_o, e.src == S_DC);
                end
            end else if (ic_gnt_o || dc_gnt_o) begin
                total++;
                bad++;
                $display("FAIL gnt_no_hs: got ic=%0b dc=%0b want none", ic_gnt_o, dc_gnt_o);
            end
            if (ic_rvalid_o || dc_rvalid_o) begin
                if (exp_rsp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rvalid_unexpected: got ic=%0b dc=%0b want none", ic_rvalid_o, dc_rvalid_o);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("ic_rvalid", ic_rvalid_o, r.src == S_IC);
                    chk("dc_rvalid", dc_rvalid_o, r.src == S_DC);
                    chk("rdata", rdata_o, r.data);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int unsigned cnt;
        rst_n = 1'b0;
        prog_req_i = 1'b0; prog_lock_i = 1'b0; prog_addr_i = '0; prog_wdata_i = '0; prog_wstrb_i = '0;
        ic_req_i = 1'b1; ic_addr_i = 32'h40;
        dc_req_i = 1'b0; dc_we_i = 1'b0; dc_addr_i = '0; dc_wdata_i = '0; dc_wstrb_i = '0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = '0;

        // Reset: outputs quiet even with live requests and responses
        repeat (3) step();
        smp();
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_ic_gnt", ic_gnt_o, 1'b0);
        chk("rst_rvalid", {ic_rvalid_o, dc_rvalid_o}, 2'b00);
        chk("rst_ovf", prog_overflow_o, 1'b0);
        chk("rst_err", resp_err_o, 1'b0);
        step();
        rst_n = 1'b1; ic_req_i = 1'b0; mem_rvalid_i = 1'b0;
        smp();
        chk("rst_err_after", resp_err_o, 1'b0);

        // Programmer burst of three words, issued N+1..N+3
        step();
        prog_word(32'h0, 1'b1);
        smp(); chk("prog_cycle_n", mem_req_o, 1'b0);
        step(); prog_word(32'h10, 1'b1);
        smp(); chk("prog_n1", mem_req_o, 1'b1);
        step(); prog_word(32'h20, 1'b1);
        smp(); chk("prog_n2", mem_req_o, 1'b1);
        step(); prog_req_i = 1'b0;
        smp(); chk("prog_n3", mem_req_o, 1'b1);
        step();
        smp(); chk("prog_idle", mem_req_o, 1'b0);

        // ic and dc reads together: ic, dc, ic, dc
        step();
        ic_req_i = 1'b1; ic_addr_i = 32'h100;
        dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h200;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_rd(S_IC, 32'h100, D_IC);
            else            exp_rd(S_DC, 32'h200, D_DC);
            smp();
            step();
        end
        ic_req_i = 1'b0; dc_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = (i % 2 == 0) ? D_IC : D_DC;
            smp();
            step();
        end
        mem_rvalid_i = 1'b0;

        // Lock blocks CPU for 100 cycles, release grants the same cycle
        prog_lock_i = 1'b1; ic_req_i = 1'b1; ic_addr_i = 32'h180;
        cnt = 0;
        repeat (100) begin
            smp();
            if (ic_gnt_o || mem_req_o) cnt++;
            step();
        end
        chk("lock_no_gnt", cnt, 0);
        prog_lock_i = 1'b0;
        exp_rd(S_IC, 32'h180, D_IC);
        smp(); chk("unlock_ic_gnt", ic_gnt_o, 1'b1);
        step();
        ic_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = D_IC;
        smp();
        step();
        mem_rvalid_i = 1'b0;

        // Stalled dc write holds the port over a newly buffered programmer word
        mem_gnt_i = 1'b0;
        dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h300;
        dc_wdata_i = {4{32'hD00D_F00D}}; dc_wstrb_i = 16'h00FF;
        exp_mem.push_back('{src: S_DC, we: 1'b1, addr: 32'h300, wdata: {4{32'hD00D_F00D}}, wstrb: 16'h00FF});
        prog_word(32'h340, 1'b1);
        cnt = 0;
        repeat (5) begin
            smp();
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_we_o !== 1'b1) cnt++;
            step();
            prog_req_i = 1'b0;
        end
        chk("hold_dc_fields", cnt, 0);
        mem_gnt_i = 1'b1;
        smp(); chk("hold_dc_gnt", dc_gnt_o, 1'b1);
        step();
        dc_req_i = 1'b0;
        smp(); chk("prog_after_hold", mem_addr_o, 32'h340);
        step();
        smp(); chk("hold_idle", mem_req_o, 1'b0);

        // Outstanding limit: 5th ic read waits for a response, same-cycle pop frees it
        step();
        ic_req_i = 1'b1; ic_addr_i = 32'h400;
        for (int i = 0; i < 4; i++) begin
            exp_rd(S_IC, 32'h400, D_IC);
            smp();
            step();
        end
        cnt = 0;
        repeat (2) begin
            smp();
            if (ic_gnt_o || mem_req_o) cnt++;
            step();
        end
        chk("id_full_block", cnt, 0);
        mem_rvalid_i = 1'b1; mem_rdata_i = D_IC;
        exp_rd(S_IC, 32'h400, D_IC);
        smp(); chk("pop_permits_gnt", ic_gnt_o, 1'b1);
        step();
        ic_req_i = 1'b0;
        repeat (4) begin
            smp();
            step();
        end
        mem_rvalid_i = 1'b0;

        // Overflow: third word into a stalled depth-2 FIFO is dropped
        mem_gnt_i = 1'b0;
        prog_word(32'h500, 1'b1);
        smp(); step();
        prog_word(32'h510, 1'b1);
        smp(); step();
        prog_word(32'h520, 1'b0);
        smp(); chk("ovf_before", prog_overflow_o, 1'b0);
        step();
        prog_req_i = 1'b0;
        smp(); chk("ovf_set", prog_overflow_o, 1'b1);
        step();
        mem_gnt_i = 1'b1;
        smp(); step();
        smp(); step();
        smp(); chk("ovf_only_two", mem_req_o, 1'b0);

        // Response with nothing outstanding
        chk("err_before", resp_err_o, 1'b0);
        step();
        mem_rvalid_i = 1'b1;
        smp(); chk("err_no_rvalid", {ic_rvalid_o, dc_rvalid_o}, 2'b00);
        step();
        mem_rvalid_i = 1'b0;
        smp(); chk("err_set", resp_err_o, 1'b1);
        chk("ovf_sticky", prog_overflow_o, 1'b1);

        // Reset with a buffered, stalled write discards it and clears flags
        step();
        mem_gnt_i = 1'b0;
        prog_word(32'h600, 1'b0);
        step();
        prog_req_i = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; mem_gnt_i = 1'b1;
        smp();
        chk("rst_mid_req", mem_req_o, 1'b0);
        chk("rst_mid_ovf", prog_overflow_o, 1'b0);
        chk("rst_mid_err", resp_err_o, 1'b0);
        step();
        smp();
        chk("rst_mid_idle", mem_req_o, 1'b0);

        step();
        chk("exp_mem_left", exp_mem.size(), 0);
        chk("exp_rsp_left", exp_rsp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
